sync_fwft_fifo: RTL and testbench

SYNC_FWFT_FIFO -- requirements
Module: sync_fwft_fifo

---
 rtl/sync_fwft_fifo.sv | 129 ++++++++++++
 tb/tb_sync_fwft_fifo.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fwft_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and almost-full/almost-empty flags.
// Latency: a word written into an empty FIFO appears on o_data one edge after it is accepted; then 1 word/cycle.
// Backpressure: i_ready = (o_count < DEPTH) from registered count; writes when not ready are dropped.
//
// Ports:
//   clock, reset_n (async active-low), clear (synchronous flush)
//   i_data/i_valid/i_ready  : write side
//   o_read/o_data/o_valid   : FWFT read side (o_read is a pop when o_valid is high)
//   o_count                 : occupancy, including the word shown on o_data
//   o_almost_full/o_almost_empty : registered threshold flags
//   o_overflow/o_underflow  : sticky error flags, built only with SYNC_FWFT_FIFO_ERR_EN defined,
//                             otherwise tied to 0
module sync_fwft_fifo #(
  parameter int NBITS      = 64,
  parameter int DEPTH_LOG2 = 9,
  parameter int AFULL      = (2 ** DEPTH_LOG2) - 64,
  parameter int AEMPTY     = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic [NBITS-1:0]      i_data,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic                  o_read,
  output logic [NBITS-1:0]      o_data,
  output logic                  o_valid,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int                   DEPTH      = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]  FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]  CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = (DEPTH_LOG2)'(1);

  logic [NBITS-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  wr_en;
  logic                  rd_en;
  logic [DEPTH_LOG2:0]   count_nxt;
  logic                  valid_nxt;

  // Ready depends only on the registered count, so a pop never opens a slot in the same cycle.
  assign i_ready = (o_count < FULL_COUNT);
  assign wr_en   = i_valid & i_ready;
  assign rd_en   = o_read & o_valid;

  // The head word is read straight from storage; it only changes when rd_ptr moves or on a write
  // into the slot rd_ptr points at, which can only happen while o_valid is still low.
  assign o_data = mem[rd_ptr];

  always_comb begin
    count_nxt = o_count;
    case ({wr_en, rd_en})
      2'b10:   count_nxt = o_count + CNT_ONE;
      2'b01:   count_nxt = o_count - CNT_ONE;
      default: count_nxt = o_count;
    endcase
  end

  // A word landing in an empty FIFO needs one extra edge before it is shown. Once something was
  // held before this edge, the head slot was written at least one edge ago, so the word after a
  // pop (including one written at this same edge at occupancy 1) can be shown right away.
  assign valid_nxt = (count_nxt != '0) && (o_count != '0);

  always_ff @(posedge clock) begin
    if (wr_en && !clear) begin
      mem[wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      o_count        <= '0;
      o_valid        <= 1'b0;
      o_almost_full  <= 1'b0;
      o_almost_empty <= 1'b1;
    end else if (clear) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      o_count        <= '0;
      o_valid        <= 1'b0;
      o_almost_full  <= (AFULL <= 0);
      o_almost_empty <= (AEMPTY > 0);
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      o_count        <= count_nxt;
      o_valid        <= valid_nxt;
      o_almost_full  <= (int'(count_nxt) >= AFULL);
      o_almost_empty <= (int'(count_nxt) < AEMPTY);
    end
  end

`ifdef SYNC_FWFT_FIFO_ERR_EN
  // Sticky error flags: a dropped write or an ignored read sets them until reset or clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else if (clear) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (i_valid && !i_ready) begin
        o_overflow <= 1'b1;
      end
      if (o_read && !o_valid) begin
        o_underflow <= 1'b1;
      end
    end
  end
`else
  assign o_overflow  = 1'b0;
  assign o_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fwft_fifo.sv
// Self-checking bench for sync_fwft_fifo at DEPTH_LOG2=4, AFULL=12, AEMPTY=4, NBITS=8.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 time unit after the edge.
// Accepted writes go into a scoreboard queue; each pop compares o_data against its head.
module tb_sync_fwft_fifo;

  localparam int NB = 8;
  localparam int DL = 4;
  localparam int DEPTH = 16;
`ifdef SYNC_FWFT_FIFO_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset_n;
  logic          clear;
  logic [NB-1:0] i_data;
  logic          i_valid;
  logic          i_ready;
  logic          o_read;
  logic [NB-1:0] o_data;
  logic          o_valid;
  logic [DL:0]   o_count;
  logic          o_almost_full;
  logic          o_almost_empty;
  logic          o_overflow;
  logic          o_underflow;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  logic [NB-1:0] q[$];
  bit            m_valid = 1'b0;
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;

  sync_fwft_fifo #(
    .NBITS(NB), .DEPTH_LOG2(DL), .AFULL(12), .AEMPTY(4)
  ) dut (
    .clock(clock), .reset_n(reset_n), .clear(clear),
    .i_data(i_data), .i_valid(i_valid), .i_ready(i_ready),
    .o_read(o_read), .o_data(o_data), .o_valid(o_valid),
    .o_count(o_count), .o_almost_full(o_almost_full), .o_almost_empty(o_almost_empty),
    .o_overflow(o_overflow), .o_underflow(o_underflow)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock edge plus the model update; pops are scored against the queue head here.
  task automatic tick();
    bit wr, rd;
    int old_size;
    wr = i_valid && (q.size() < DEPTH);
    rd = o_read && m_valid;
    if (rd && !clear) begin
      tests_run++;
      if (o_data !== q[0]) begin
        tests_failed++;
        $display("FAIL pop_data: got %h expected %h", o_data, q[0]);
      end
    end
    @(posedge clock);
    #1;
    old_size = q.size();
    if (clear) begin
      q.delete();
      m_valid = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (ERR && i_valid && !(old_size < DEPTH)) m_ovf = 1'b1;
      if (ERR && o_read && !m_valid) m_unf = 1'b1;
      if (rd) void'(q.pop_front());
      if (wr) q.push_back(i_data);
      m_valid = (q.size() > 0) && (old_size > 0);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clear = 1'b0; i_valid = 1'b0; i_data = '0; o_read = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    tests_run++; if (o_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b expected 0", o_valid); end
    tests_run++; if (o_count !== 5'd0) begin tests_failed++; $display("FAIL rst_count: got %0d expected 0", o_count); end
    tests_run++; if (i_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_ready: got %b expected 1", i_ready); end
    tests_run++; if (o_almost_full !== 1'b0) begin tests_failed++; $display("FAIL rst_afull: got %b expected 0", o_almost_full); end
    tests_run++; if (o_almost_empty !== 1'b1) begin tests_failed++; $display("FAIL rst_aempty: got %b expected 1", o_almost_empty); end
    tests_run++; if (o_overflow !== 1'b0 || o_underflow !== 1'b0) begin
      tests_failed++; $display("FAIL rst_err: got ovf=%b unf=%b expected 0 0", o_overflow, o_underflow);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_first_word();
    i_valid = 1'b1; i_data = 8'h11;
    tick();
    i_valid = 1'b0;
    tests_run++; if (o_valid !== 1'b0) begin tests_failed++; $display("FAIL fw_valid_edge0: got %b expected 0", o_valid); end
    tests_run++; if (o_count !== 5'd1) begin tests_failed++; $display("FAIL fw_count_edge0: got %0d expected 1", o_count); end
    tick();
    tests_run++; if (o_valid !== 1'b1) begin tests_failed++; $display("FAIL fw_valid_edge1: got %b expected 1", o_valid); end
    tests_run++; if (o_data !== 8'h11) begin tests_failed++; $display("FAIL fw_data_edge1: got %h expected 11", o_data); end
    tests_run++; if (o_count !== 5'd1 || o_almost_empty !== 1'b1) begin
      tests_failed++; $display("FAIL fw_count_aempty: got count=%0d aempty=%b expected 1 1", o_count, o_almost_empty);
    end
    tick();
    tests_run++; if (o_data !== 8'h11 || o_valid !== 1'b1) begin
      tests_failed++; $display("FAIL fw_hold: got data=%h valid=%b expected 11 1", o_data, o_valid);
    end
    o_read = 1'b1;
    tick();
    o_read = 1'b0;
    tests_run++; if (o_valid !== 1'b0 || o_count !== 5'd0) begin
      tests_failed++; $display("FAIL fw_pop_empty: got valid=%b count=%0d expected 0 0", o_valid, o_count);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      i_valid = 1'b1; i_data = 8'hA0 + 8'(i);
      tick();
      tests_run++;
      if (o_count !== 5'(i + 1) || o_almost_full !== ((i + 1) >= 12) || o_almost_empty !== ((i + 1) < 4)) begin
        tests_failed++;
        $display("FAIL fill_flags_%0d: got count=%0d afull=%b aempty=%b expected %0d %b %b",
                 i, o_count, o_almost_full, o_almost_empty, i + 1, (i + 1) >= 12, (i + 1) < 4);
      end
    end
    tests_run++; if (i_ready !== 1'b0) begin tests_failed++; $display("FAIL fill_ready: got %b expected 0", i_ready); end
    i_data = 8'hFF;
    tick();
    i_valid = 1'b0;
    tests_run++; if (o_count !== 5'd16) begin tests_failed++; $display("FAIL fill_drop_count: got %0d expected 16", o_count); end
    tests_run++; if (o_overflow !== m_ovf) begin tests_failed++; $display("FAIL fill_overflow: got %b expected %b", o_overflow, m_ovf); end
    tests_run++; if (o_data !== 8'hA0) begin tests_failed++; $display("FAIL fill_head: got %h expected a0", o_data); end
  endtask

  task automatic test_full_write_pop();
    i_valid = 1'b1; i_data = 8'hEE; o_read = 1'b1;
    tick();
    i_valid = 1'b0; o_read = 1'b0;
    tests_run++; if (o_count !== 5'd15) begin tests_failed++; $display("FAIL fwp_count: got %0d expected 15", o_count); end
    tests_run++; if (o_data !== 8'hA1) begin tests_failed++; $display("FAIL fwp_data: got %h expected a1", o_data); end
    tests_run++; if (i_ready !== 1'b1) begin tests_failed++; $display("FAIL fwp_ready: got %b expected 1", i_ready); end
    for (int n = 0; n < 40 && q.size() > 0; n++) begin
      o_read = m_valid;
      tick();
    end
    o_read = 1'b0;
    tests_run++; if (o_count !== 5'd0 || o_valid !== 1'b0) begin
      tests_failed++; $display("FAIL fwp_drain: got count=%0d valid=%b expected 0 0", o_count, o_valid);
    end
  endtask

  task automatic test_stream();
    int sent = 0;
    int received = 0;
    int gaps = 0;
    bit primed = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tests_run++; if (o_overflow !== 1'b0) begin tests_failed++; $display("FAIL clr_overflow: got %b expected 0", o_overflow); end
    for (int n = 0; n < 200 && received < 40; n++) begin
      i_valid = (sent < 40); i_data = 8'(sent); o_read = 1'b1;
      if (i_valid && q.size() < DEPTH) sent++;
      if (o_read && m_valid) received++;
      tick();
      if (o_valid) primed = 1'b1;
      else if (primed && received < 40) gaps++;
    end
    i_valid = 1'b0; o_read = 1'b0;
    tests_run++; if (received !== 40) begin tests_failed++; $display("FAIL stream_count: got %0d expected 40", received); end
    tests_run++; if (gaps !== 0) begin tests_failed++; $display("FAIL stream_gaps: got %0d expected 0", gaps); end
    tests_run++; if (o_underflow !== m_unf) begin tests_failed++; $display("FAIL stream_underflow: got %b expected %b", o_underflow, m_unf); end
  endtask

  task automatic test_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      i_valid = 1'b1; i_data = 8'h50 + 8'(i);
      tick();
    end
    i_valid = 1'b0;
    tick();
    tests_run++; if (o_count !== 5'd5 || o_valid !== 1'b1) begin
      tests_failed++; $display("FAIL clr_pre: got count=%0d valid=%b expected 5 1", o_count, o_valid);
    end
    clear = 1'b1; i_valid = 1'b1; i_data = 8'h77; o_read = 1'b1;
    tick();
    clear = 1'b0; i_valid = 1'b0; o_read = 1'b0;
    tests_run++; if (o_valid !== 1'b0 || o_count !== 5'd0) begin
      tests_failed++; $display("FAIL clr_post: got valid=%b count=%0d expected 0 0", o_valid, o_count);
    end
    tests_run++; if (o_almost_empty !== 1'b1 || o_underflow !== 1'b0) begin
      tests_failed++; $display("FAIL clr_flags: got aempty=%b unf=%b expected 1 0", o_almost_empty, o_underflow);
    end
    o_read = 1'b1;
    tick();
    o_read = 1'b0;
    tests_run++; if (o_underflow !== m_unf) begin tests_failed++; $display("FAIL clr_underflow: got %b expected %b", o_underflow, m_unf); end
    tests_run++; if (o_count !== 5'd0) begin tests_failed++; $display("FAIL clr_empty_read: got %0d expected 0", o_count); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 8; i++) begin
      i_valid = 1'b1; i_data = 8'h80 + 8'(i);
      tick();
    end
    i_valid = 1'b0;
    tests_run++; if (o_count !== 5'd8) begin tests_failed++; $display("FAIL ar_pre: got %0d expected 8", o_count); end
    #2;
    reset_n = 1'b0;
    #1;
    q.delete(); m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    tests_run++; if (o_valid !== 1'b0 || o_count !== 5'd0 || i_ready !== 1'b1) begin
      tests_failed++; $display("FAIL ar_main: got valid=%b count=%0d ready=%b expected 0 0 1", o_valid, o_count, i_ready);
    end
    tests_run++; if (o_almost_full !== 1'b0 || o_almost_empty !== 1'b1 || o_overflow !== 1'b0 || o_underflow !== 1'b0) begin
      tests_failed++; $display("FAIL ar_flags: got afull=%b aempty=%b ovf=%b unf=%b expected 0 1 0 0",
                               o_almost_full, o_almost_empty, o_overflow, o_underflow);
    end
    #2;
    reset_n = 1'b1;
    i_valid = 1'b1; i_data = 8'h3C;
    tick();
    i_valid = 1'b0;
    tests_run++; if (o_count !== 5'd1) begin tests_failed++; $display("FAIL ar_first_write: got %0d expected 1", o_count); end
    tick();
    tests_run++; if (o_valid !== 1'b1 || o_data !== 8'h3C) begin
      tests_failed++; $display("FAIL ar_first_data: got valid=%b data=%h expected 1 3c", o_valid, o_data);
    end
    o_read = 1'b1;
    tick();
    o_read = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_fill();
    test_full_write_pop();
    test_stream();
    test_clear();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
